// File: rtl/funnel_seq_4_1.sv
// Word-to-lane funnel: holds one 4-lane input word and emits 4, 2 or 1 lanes
// in order 0..3, handing over to the next word on the last lane without a bubble.
module funnel_seq_4_1 #(
    parameter int LANE_W = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*LANE_W-1:0]   t_0_dat,
    input  logic                  t_0_valid,
    output logic                  t_0_ready,
    input  logic [7:0]            t_cfg_dat,
    output logic [LANE_W-1:0]     i_0_dat,
    output logic                  i_0_valid,
    input  logic                  i_0_ready,
    output logic                  i_0_last,
    output logic [7:0]            sel,
    output logic [7:0]            mode
);

    // state    | meaning
    // ST_IDLE  | no word held, ready for a new word
    // ST_DRAIN | word held, presenting lane r_cnt
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_cnt;
    logic [1:0]          w_cnt_nxt;
    logic [4*LANE_W-1:0] r_data;
    logic [7:0]          r_mode;
    logic [1:0]          w_last_idx;
    logic [1:0]          w_lane;
    logic                w_last;
    logic                w_load;

    // Lane-count code of the held word; code 3 is reserved and behaves as 4 lanes.
    always_comb begin
        case (r_mode[1:0])
            2'd1:    w_last_idx = 2'd1;
            2'd2:    w_last_idx = 2'd0;
            default: w_last_idx = 2'd3;
        endcase
    end

    assign w_last = (r_state == ST_DRAIN) && (r_cnt == w_last_idx);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        t_0_ready   = 1'b0;
        i_0_valid   = 1'b0;
        i_0_last    = 1'b0;
        sel         = 8'h00;
        case (r_state)
            ST_IDLE: begin
                t_0_ready = 1'b1;
                if (t_0_valid) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = 2'd0;
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                i_0_valid = 1'b1;
                i_0_last  = w_last;
                // sel[1] marks an odd lane, sel[0] the upper lane pair
                sel       = {6'b0, r_cnt[0], r_cnt[1]};
                t_0_ready = w_last & i_0_ready;
                if (i_0_ready) begin
                    if (w_last) begin
                        w_cnt_nxt = 2'd0;
                        if (t_0_valid) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 2'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
            r_mode <= 8'h00;
        end else if (w_load) begin
            r_data <= t_0_dat;
            r_mode <= t_cfg_dat;
        end
    end

    assign w_lane = {sel[0], sel[1]};
    assign mode   = r_mode;

    always_comb begin
        case (w_lane)
            2'd0:    i_0_dat = r_data[LANE_W-1:0];
            2'd1:    i_0_dat = r_data[2*LANE_W-1:LANE_W];
            2'd2:    i_0_dat = r_data[3*LANE_W-1:2*LANE_W];
            default: i_0_dat = r_data[4*LANE_W-1:3*LANE_W];
        endcase
    end

endmodule

// File: tb/tb_funnel_seq_4_1.sv
// Scoreboard bench for funnel_seq_4_1: directed scenarios followed by random traffic,
// compared lane by lane against a queue-based reference model.
module tb_funnel_seq_4_1;

    localparam int LW = 128;

    logic            clk;
    logic            reset;
    logic [4*LW-1:0] t_0_dat;
    logic            t_0_valid;
    logic            t_0_ready;
    logic [7:0]      t_cfg_dat;
    logic [LW-1:0]   i_0_dat;
    logic            i_0_valid;
    logic            i_0_ready;
    logic            i_0_last;
    logic [7:0]      sel;
    logic [7:0]      mode;

    funnel_seq_4_1 #(.LANE_W(LW)) dut (
        .clk       (clk),
        .reset     (reset),
        .t_0_dat   (t_0_dat),
        .t_0_valid (t_0_valid),
        .t_0_ready (t_0_ready),
        .t_cfg_dat (t_cfg_dat),
        .i_0_dat   (i_0_dat),
        .i_0_valid (i_0_valid),
        .i_0_ready (i_0_ready),
        .i_0_last  (i_0_last),
        .sel       (sel),
        .mode      (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [LW-1:0] dat;
        logic [7:0]    sel;
        logic          last;
        logic [7:0]    mode;
    } lane_t;

    lane_t         q[$];
    int            errors = 0;
    int            checks = 0;
    logic [7:0]    idle_mode = 8'h00;
    logic [LW-1:0] idle_dat = '0;
    logic [7:0]    sel_tbl [4];

    initial begin
        sel_tbl[0] = 8'd0;
        sel_tbl[1] = 8'd2;
        sel_tbl[2] = 8'd1;
        sel_tbl[3] = 8'd3;
    end

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int lanes_of(input logic [7:0] cfg);
        case (cfg[1:0])
            2'd1:    return 2;
            2'd2:    return 1;
            default: return 4;
        endcase
    endfunction

    // Monitor + reference model: compare at the falling edge, then advance the model.
    initial begin
        lane_t e;
        logic  exp_ready;
        int    n;
        @(posedge clk);
        forever begin
            @(negedge clk);
            exp_ready = (q.size() == 0) || (q.size() == 1 && i_0_ready);
            chk("t_0_ready", LW'(t_0_ready), LW'(exp_ready));
            if (q.size() == 0) begin
                chk("idle_valid", LW'(i_0_valid), '0);
                chk("idle_last", LW'(i_0_last), '0);
                chk("idle_sel", LW'(sel), '0);
                chk("idle_mode", LW'(mode), LW'(idle_mode));
                chk("idle_dat", i_0_dat, idle_dat);
            end else begin
                e = q[0];
                chk("valid", LW'(i_0_valid), LW'(1'b1));
                chk("dat", i_0_dat, e.dat);
                chk("sel", LW'(sel), LW'(e.sel));
                chk("last", LW'(i_0_last), LW'(e.last));
                chk("mode", LW'(mode), LW'(e.mode));
            end
            if (reset) begin
                q.delete();
                idle_mode = 8'h00;
                idle_dat  = '0;
            end else begin
                if (q.size() > 0 && i_0_ready) void'(q.pop_front());
                if (t_0_valid && exp_ready) begin
                    n = lanes_of(t_cfg_dat);
                    for (int k = 0; k < n; k++) begin
                        e.dat  = t_0_dat[k*LW +: LW];
                        e.sel  = sel_tbl[k];
                        e.last = (k == n - 1);
                        e.mode = t_cfg_dat;
                        q.push_back(e);
                    end
                    idle_mode = t_cfg_dat;
                    idle_dat  = t_0_dat[LW-1:0];
                end
            end
        end
    end

    task automatic cyc(input logic rst, input logic v, input logic [4*LW-1:0] d,
                       input logic [7:0] cfg, input logic rdy);
        reset     = rst;
        t_0_valid = v;
        t_0_dat   = d;
        t_cfg_dat = cfg;
        i_0_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4*LW-1:0] rand_word();
        logic [4*LW-1:0] w;
        for (int i = 0; i < 16; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    initial begin
        logic [4*LW-1:0] wa;
        logic [4*LW-1:0] w1;
        logic [4*LW-1:0] w2;
        wa = {128'hD, 128'hC, 128'hB, 128'hA};
        w1 = rand_word();
        w2 = rand_word();
        reset = 1'b1; t_0_valid = 1'b0; t_0_dat = '0; t_cfg_dat = 8'h00; i_0_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc(1'b0, 1'b0, '0, 8'h00, 1'b0);

        // four lanes A..D, full throughput
        cyc(1'b0, 1'b1, wa, 8'h00, 1'b1);
        repeat (4) cyc(1'b0, 1'b0, '0, 8'h00, 1'b1);
        cyc(1'b0, 1'b0, '0, 8'h00, 1'b0);

        // 2-lane word then 1-lane word, handed over on the last lane
        cyc(1'b0, 1'b1, w1, 8'h01, 1'b1);
        cyc(1'b0, 1'b1, w2, 8'h02, 1'b1);
        cyc(1'b0, 1'b1, w2, 8'h02, 1'b1);
        cyc(1'b0, 1'b0, '0, 8'h00, 1'b1);
        cyc(1'b0, 1'b0, '0, 8'h00, 1'b0);

        // downstream stall holds lane 1
        cyc(1'b0, 1'b1, rand_word(), 8'h00, 1'b1);
        cyc(1'b0, 1'b0, '0, 8'h00, 1'b1);
        cyc(1'b0, 1'b0, '0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, '0, 8'h00, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, '0, 8'h00, 1'b1);

        // cfg change mid-drain does not affect the held word
        cyc(1'b0, 1'b1, rand_word(), 8'h00, 1'b1);
        repeat (4) cyc(1'b0, 1'b0, '0, 8'h02, 1'b1);

        // reset during lane 2 of 4, then a fresh word
        cyc(1'b0, 1'b1, rand_word(), 8'h00, 1'b1);
        cyc(1'b0, 1'b0, '0, 8'h00, 1'b1);
        cyc(1'b0, 1'b0, '0, 8'h00, 1'b1);
        cyc(1'b1, 1'b1, rand_word(), 8'h00, 1'b0);
        cyc(1'b0, 1'b0, '0, 8'h00, 1'b1);
        cyc(1'b0, 1'b1, rand_word(), 8'h00, 1'b1);
        repeat (4) cyc(1'b0, 1'b0, '0, 8'h00, 1'b1);

        // reserved code 3 behaves as 4 lanes
        cyc(1'b0, 1'b1, rand_word(), 8'h03, 1'b1);
        repeat (4) cyc(1'b0, 1'b0, '0, 8'h03, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1), rand_word(),
                8'($urandom), ($urandom_range(0, 9) < 7));
        end

        repeat (8) cyc(1'b0, 1'b0, '0, 8'h00, 1'b1);
        chk("drain_empty", LW'(q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
